// File: rtl/rr_fifo_scheduler.sv
// Round-robin scheduler draining four show-ahead FIFOs onto one registered
// valid/ready output. A port holds its grant until end-of-packet or BURST_MAX beats.
module rr_fifo_scheduler #(
  parameter int DATA_W    = 4,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req_valid,
  input  logic [3:0]        req_last,
  input  logic [DATA_W-1:0] req_data0,
  input  logic [DATA_W-1:0] req_data1,
  input  logic [DATA_W-1:0] req_data2,
  input  logic [DATA_W-1:0] req_data3,
  output logic [3:0]        pop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              out_last,
  output logic              busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]        r_state;
  logic [1:0]        r_ptr;
  logic [1:0]        r_gnt;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [1:0]        r_out_sel;
  logic              r_out_last;

  logic [DATA_W-1:0] w_head_data;
  logic [1:0]        w_pick;
  logic              w_can_load;
  logic              w_pop_en;
  logic              w_burst_end;
  logic              w_release;

  // First requesting port at or after p, wrapping 3 -> 0.
  function automatic logic [1:0] f_rr_pick(input logic [3:0] v, input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    f_rr_pick = p;
    found     = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && v[idx]) begin
        f_rr_pick = idx;
        found     = 1'b1;
      end
    end
  endfunction

  always_comb begin
    w_head_data = req_data0;
    case (r_gnt)
      2'd0:    w_head_data = req_data0;
      2'd1:    w_head_data = req_data1;
      2'd2:    w_head_data = req_data2;
      default: w_head_data = req_data3;
    endcase
  end

  assign w_pick      = f_rr_pick(req_valid, r_ptr);
  assign w_can_load  = !r_out_valid || out_ready;
  assign w_pop_en    = (r_state == S_GRANT) && req_valid[r_gnt] && w_can_load;
  assign w_burst_end = (r_beat_cnt == CNT_W'(BURST_MAX - 1));
  // A stalled output with data pending holds the grant; an empty FIFO gives it up.
  assign w_release   = (r_state == S_GRANT) &&
                       (!req_valid[r_gnt] || (w_pop_en && (req_last[r_gnt] || w_burst_end)));

  assign pop       = w_pop_en ? (4'b0001 << r_gnt) : 4'b0000;
  assign busy      = (r_state == S_GRANT);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;
  assign out_last  = r_out_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_gnt      <= 2'd0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_gnt      <= w_pick;
            r_beat_cnt <= '0;
            r_state    <= S_GRANT;
          end
        end
        default: begin
          if (w_pop_en) r_beat_cnt <= r_beat_cnt + 1'b1;
          if (w_release) begin
            r_state <= S_IDLE;
            r_ptr   <= r_gnt + 2'd1;
          end
        end
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= 2'd0;
      r_out_last  <= 1'b0;
    end else if (w_pop_en) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head_data;
      r_out_sel   <= r_gnt;
      r_out_last  <= req_last[r_gnt];
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_fifo_scheduler.sv
// Directed bench for rr_fifo_scheduler: four modelled show-ahead FIFOs feed the
// scheduler and every accepted output beat is logged with its cycle number.
module tb_rr_fifo_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_valid, req_last, pop;
  logic [3:0] req_data0, req_data1, req_data2, req_data3;
  logic       out_valid, out_ready, out_last, busy;
  logic [3:0] out_data;
  logic [1:0] out_sel;

  logic [3:0] en;
  logic [3:0] mem_d [4][32];
  logic       mem_l [4][32];
  logic [3:0] hd [4];
  int rd [4]      = '{0, 0, 0, 0};
  int wr [4]      = '{0, 0, 0, 0};
  int pop_cnt [4] = '{0, 0, 0, 0};
  int cyc  = 0;

  logic [1:0] lg_sel  [64];
  logic [3:0] lg_data [64];
  logic       lg_last [64];
  int         lg_cyc  [64];
  int         lg_n = 0;

  int n_chk  = 0;
  int n_fail = 0;
  int base, t0, p1, p3;

  int e4_sel  [7] = '{1, 1, 1, 1, 3, 1, 1};
  int e4_data [7] = '{1, 2, 3, 4, 9, 5, 6};
  int e4_last [7] = '{0, 0, 0, 0, 1, 0, 1};

  rr_fifo_scheduler #(.DATA_W(4), .BURST_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_last(req_last),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_data2(req_data2), .req_data3(req_data3),
    .pop(pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_valid = 4'b0000;
    req_last  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = en[i] && (rd[i] < wr[i]);
      req_last[i]  = mem_l[i][rd[i] & 31];
      hd[i]        = mem_d[i][rd[i] & 31];
    end
  end

  assign req_data0 = hd[0];
  assign req_data1 = hd[1];
  assign req_data2 = hd[2];
  assign req_data3 = hd[3];

  // FIFO read side follows the DUT pop strobes
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (pop[i]) begin
        rd[i]      <= rd[i] + 1;
        pop_cnt[i] <= pop_cnt[i] + 1;
      end
    end
  end

  // Beat log: sampled mid-cycle, a beat is taken when valid and ready are both high
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && lg_n < 64) begin
      lg_sel[lg_n]  <= out_sel;
      lg_data[lg_n] <= out_data;
      lg_last[lg_n] <= out_last;
      lg_cyc[lg_n]  <= cyc;
      lg_n          <= lg_n + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input logic [3:0] d, input logic l);
    mem_d[p][wr[p] & 31] = d;
    mem_l[p][wr[p] & 31] = l;
    wr[p] = wr[p] + 1;
  endtask

  task automatic wait_log(input int target, input string tag);
    for (int k = 0; k < 80 && lg_n < target; k++) tick;
    tick;
    chk(tag, lg_n, target);
  endtask

  task automatic chk_beat(input string tag, input int idx, input int sel, input int data, input int last);
    chk({tag, "_sel"},  32'(lg_sel[idx]),  sel);
    chk({tag, "_data"}, 32'(lg_data[idx]), data);
    chk({tag, "_last"}, 32'(lg_last[idx]), last);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_data"},  32'(out_data),  0);
    chk({tag, "_sel"},   32'(out_sel),   0);
    chk({tag, "_last"},  32'(out_last),  0);
    chk({tag, "_pop"},   32'(pop),       0);
    chk({tag, "_busy"},  32'(busy),      0);
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    en        = 4'hF;
    repeat (3) tick;
    chk_idle_outputs("reset");
    rst = 1'b0;
    tick;
    chk_idle_outputs("idle_after_reset");

    // Single-beat packets on all ports: rotation 0,1,2,3,0 with an IDLE cycle between grants
    base = lg_n;
    t0   = cyc;
    push(0, 4'h1, 1'b1); push(1, 4'h2, 1'b1); push(2, 4'h3, 1'b1); push(3, 4'h4, 1'b1);
    push(0, 4'h5, 1'b1);
    tick;
    chk("rot_busy", 32'(busy), 1);
    chk("rot_pop0", 32'(pop), 32'(4'b0001));
    wait_log(base + 5, "rot_count");
    for (int i = 0; i < 5; i++) begin
      chk_beat("rot", base + i, i % 4, i + 1, 1);
      chk("rot_cycle", lg_cyc[base + i], t0 + 2 + 2 * i);
    end

    // ptr now 1; ports 0 and 2 only -> 2 first, then 0
    base = lg_n;
    p1 = pop_cnt[1];
    p3 = pop_cnt[3];
    push(0, 4'h6, 1'b1); push(2, 4'h7, 1'b1);
    wait_log(base + 2, "skip_count");
    chk_beat("skip0", base,     2, 7, 1);
    chk_beat("skip1", base + 1, 0, 6, 1);
    chk("skip_pop1", pop_cnt[1], p1);
    chk("skip_pop3", pop_cnt[3], p3);

    // Burst truncation: 6-beat packet on port 1 splits 4 + 2 around port 3
    base = lg_n;
    for (int i = 1; i <= 6; i++) push(1, 4'(i), (i == 6));
    push(3, 4'h9, 1'b1);
    wait_log(base + 7, "burst_count");
    for (int i = 0; i < 7; i++) chk_beat("burst", base + i, e4_sel[i], e4_data[i], e4_last[i]);

    // Backpressure: first beat A parks in the output register for 3 cycles
    base = lg_n;
    out_ready = 1'b0;
    push(0, 4'hA, 1'b0); push(0, 4'hB, 1'b0); push(0, 4'hC, 1'b1);
    for (int k = 0; k < 20 && !out_valid; k++) tick;
    chk("bp_valid", 32'(out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick;
      chk("bp_hold_data", 32'(out_data), 32'(4'hA));
      chk("bp_hold_pop", 32'(pop), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_pop", 32'(pop), 32'(4'b0001));
    tick;
    chk("bp_next_valid", 32'(out_valid), 1);
    chk("bp_next_data", 32'(out_data), 32'(4'hB));
    tick;
    chk("bp_last_data", 32'(out_data), 32'(4'hC));
    chk("bp_last_flag", 32'(out_last), 1);
    wait_log(base + 3, "bp_count");
    chk_beat("bp0", base,     0, 10, 0);
    chk_beat("bp1", base + 1, 0, 11, 0);
    chk_beat("bp2", base + 2, 0, 12, 1);
    chk("bp_gap1", lg_cyc[base + 1], lg_cyc[base] + 1);
    chk("bp_gap2", lg_cyc[base + 2], lg_cyc[base] + 2);

    // Port 2 runs dry after 2 of 4 beats; port 3 gets in, then port 2 resumes
    base = lg_n;
    push(2, 4'h1, 1'b0); push(2, 4'h2, 1'b0); push(3, 4'hE, 1'b1);
    wait_log(base + 3, "dry_count_a");
    push(2, 4'h3, 1'b0); push(2, 4'h4, 1'b1);
    wait_log(base + 5, "dry_count_b");
    chk_beat("dry0", base,     2, 1,  0);
    chk_beat("dry1", base + 1, 2, 2,  0);
    chk_beat("dry2", base + 2, 3, 14, 1);
    chk_beat("dry3", base + 3, 2, 3,  0);
    chk_beat("dry4", base + 4, 2, 4,  1);

    // Reset mid-grant on port 3: outputs clear at once, then port 0 is served first
    push(0, 4'h5, 1'b1);
    for (int i = 1; i <= 4; i++) push(3, 4'(i), (i == 4));
    for (int k = 0; k < 20 && !out_valid; k++) tick;
    chk("mid_pre_sel", 32'(out_sel), 3);
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = lg_n;
    wait_log(base + 4, "mid_count");
    chk_beat("mid0", base,     0, 5, 1);
    chk_beat("mid1", base + 1, 3, 2, 0);
    chk_beat("mid2", base + 2, 3, 3, 0);
    chk_beat("mid3", base + 3, 3, 4, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
